// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the RAM access controller and its helpers.
package ram_ctrl_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 4;
    localparam int DEPTH    = 32;
    localparam int READ_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_SCAN   = 2'd3
    } state_t;

endpackage

// File: rtl/ram_access_ctrl_scan_tick_gen.sv
// scan_tick_gen: prescaler producing a registered one-cycle tick every SCAN_DIV enabled cycles.
module scan_tick_gen #(
    parameter int SCAN_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Count enabled cycles; dropping en restarts the phase from zero
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r == TERM) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + ONE;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: drives a registered-input RAM for manual writes, constant fill and a read scan.
// Defining RAM_CTRL_VERIFY_EN adds a read-back compare pass after every fill.
module ram_access_ctrl #(
    parameter int ADDR_W   = ram_ctrl_pkg::ADDR_W,
    parameter int DATA_W   = ram_ctrl_pkg::DATA_W,
    parameter int DEPTH    = ram_ctrl_pkg::DEPTH,
    parameter int SCAN_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              scan_en,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] cur_data,
    output logic              err
);

    import ram_ctrl_pkg::*;

    localparam int LAST = READ_LAT - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    state_t state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s, idx_r, idx_s, cur_addr_r, cur_addr_s;
    logic [DATA_W-1:0] din_r, din_s, fval_r, fval_s, cur_data_r, cur_data_s;
    logic we_r, we_s, done_r, done_s, busy_r, busy_s, err_r, err_s;
    logic pend_r, pend_s, restore_r, restore_s;
    logic issue_s, issue_ver_s, flush_s, step_s, tick;
    // Read pipeline: one stage per RAM latency cycle, tagged scan or verify
    logic [READ_LAT-1:0]             pv_r, pv_s, pver_r, pver_s;
    logic [READ_LAT-1:0][ADDR_W-1:0] pa_r, pa_s;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_r == ST_SCAN),
        .tick (tick)
    );

    // Next-state and next-output computation for the whole controller
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        din_s       = din_r;
        we_s        = 1'b0;
        fval_s      = fval_r;
        idx_s       = idx_r;
        done_s      = 1'b0;
        busy_s      = busy_r;
        err_s       = err_r;
        pend_s      = pend_r;
        restore_s   = 1'b0;
        issue_s     = 1'b0;
        issue_ver_s = 1'b0;
        flush_s     = 1'b0;
        step_s      = 1'b0;
        cur_addr_s  = cur_addr_r;
        cur_data_s  = cur_data_r;

        if (pv_r[LAST] && pver_r[LAST]) begin
            err_s = err_r | (ram_dout != fval_r);
        end else if (pv_r[LAST]) begin
            cur_addr_s = pa_r[LAST];
            cur_data_s = ram_dout;
        end else begin
            cur_data_s = cur_data_r;
        end

        case (state_r)
            ST_IDLE, ST_SCAN: begin
                if (fill_start) begin
                    state_s    = ST_FILL;
                    addr_s     = {ADDR_W{1'b0}};
                    din_s      = fill_value;
                    fval_s     = fill_value;
                    we_s       = 1'b1;
                    busy_s     = 1'b1;
                    err_s      = 1'b0;
                    pend_s     = 1'b0;
                    flush_s    = 1'b1;
                    cur_addr_s = cur_addr_r;
                    cur_data_s = cur_data_r;
                end else begin
                    step_s = (state_r == ST_SCAN) && scan_en && (tick || pend_r);
                    if (wr_req) begin
                        // A tick landing on a write is held over to the next free cycle
                        addr_s    = wr_addr;
                        din_s     = wr_data;
                        we_s      = 1'b1;
                        restore_s = 1'b1;
                        pend_s    = step_s;
                    end else if (step_s) begin
                        addr_s  = idx_r;
                        idx_s   = (idx_r == LAST_ADDR) ? {ADDR_W{1'b0}} : idx_r + ONE_ADDR;
                        issue_s = 1'b1;
                        pend_s  = 1'b0;
                    end else if (restore_r) begin
                        addr_s = idx_r;
                    end else begin
                        addr_s = addr_r;
                    end
                    if (scan_en) begin
                        state_s = ST_SCAN;
                    end else begin
                        state_s = ST_IDLE;
                        pend_s  = 1'b0;
                    end
                end
            end
            ST_FILL: begin
                if (addr_r == LAST_ADDR) begin
`ifdef RAM_CTRL_VERIFY_EN
                    state_s     = ST_VERIFY;
                    addr_s      = {ADDR_W{1'b0}};
                    issue_s     = 1'b1;
                    issue_ver_s = 1'b1;
`else
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
`endif
                end else begin
                    addr_s = addr_r + ONE_ADDR;
                    we_s   = 1'b1;
                end
            end
`ifdef RAM_CTRL_VERIFY_EN
            ST_VERIFY: begin
                if (pv_r[LAST] && pver_r[LAST] && (pa_r[LAST] == LAST_ADDR)) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else if (addr_r != LAST_ADDR) begin
                    addr_s      = addr_r + ONE_ADDR;
                    issue_s     = 1'b1;
                    issue_ver_s = 1'b1;
                end else begin
                    addr_s = addr_r;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase

        if (flush_s) begin
            pv_s   = {READ_LAT{1'b0}};
            pver_s = {READ_LAT{1'b0}};
            pa_s   = pa_r;
        end else begin
            pv_s   = {pv_r[READ_LAT-2:0], issue_s};
            pver_s = {pver_r[READ_LAT-2:0], issue_ver_s};
            pa_s   = {pa_r[READ_LAT-2:0], addr_s};
        end
    end

    // Register every state bit and every RAM-facing output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            din_r      <= {DATA_W{1'b0}};
            we_r       <= 1'b0;
            fval_r     <= {DATA_W{1'b0}};
            idx_r      <= {ADDR_W{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            pend_r     <= 1'b0;
            restore_r  <= 1'b0;
            cur_addr_r <= {ADDR_W{1'b0}};
            cur_data_r <= {DATA_W{1'b0}};
            pv_r       <= {READ_LAT{1'b0}};
            pver_r     <= {READ_LAT{1'b0}};
            pa_r       <= {(READ_LAT*ADDR_W){1'b0}};
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            din_r      <= din_s;
            we_r       <= we_s;
            fval_r     <= fval_s;
            idx_r      <= idx_s;
            done_r     <= done_s;
            busy_r     <= busy_s;
            err_r      <= err_s;
            pend_r     <= pend_s;
            restore_r  <= restore_s;
            cur_addr_r <= cur_addr_s;
            cur_data_r <= cur_data_s;
            pv_r       <= pv_s;
            pver_r     <= pver_s;
            pa_r       <= pa_s;
        end
    end

    assign ram_addr = addr_r;
    assign ram_din  = din_r;
    assign ram_we   = we_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign cur_addr = cur_addr_r;
    assign cur_data = cur_data_r;
    assign err      = err_r;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomised bench for ram_access_ctrl with a behavioural 32x4 registered-input RAM alongside.
module tb_ram_access_ctrl;

    localparam int AW  = 5;
    localparam int DW  = 4;
    localparam int DP  = 32;
    localparam int DIV = 4;
`ifdef RAM_CTRL_VERIFY_EN
    localparam int BUSY_EXP = 2 * DP + 1;
`else
    localparam int BUSY_EXP = DP;
`endif

    logic clk = 1'b0;
    logic rst, wr_req, fill_start, scan_en;
    logic [AW-1:0] wr_addr, ram_addr, cur_addr;
    logic [DW-1:0] wr_data, fill_value, ram_dout, ram_din, cur_data;
    logic ram_we, busy, done, err;

    logic [DW-1:0] ram_mem [DP];
    logic [AW-1:0] ram_addr_q;
    logic          flip_en = 1'b0;
    logic [DW-1:0] model [DP];

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0, we_cnt = 0, done_cnt = 0;
    logic [AW-1:0] we_addr_last;
    logic [DW-1:0] we_din_last;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .SCAN_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .fill_start(fill_start), .fill_value(fill_value), .scan_en(scan_en),
        .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .busy(busy), .done(done), .cur_addr(cur_addr), .cur_data(cur_data), .err(err)
    );

    // RAM: inputs registered on the edge, read data from the registered address
    always @(posedge clk) begin
        ram_addr_q <= ram_addr;
        if (ram_we) ram_mem[ram_addr] <= ram_din;
    end
    assign ram_dout = ram_mem[ram_addr_q] ^ ((flip_en && ram_addr_q == 5'd7) ? 4'b0001 : 4'b0000);

    // Activity counters sampled away from the active edge
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (ram_we === 1'b1) begin
            we_cnt++;
            we_addr_last = ram_addr;
            we_din_last  = ram_din;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_fill(input logic [DW-1:0] v);
        @(posedge clk); #1;
        fill_value = v;
        fill_start = 1'b1;
        @(posedge clk); #1;
        fill_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, 32'(k < 200), 32'd1);
    endtask

    task automatic fill_and_check(input logic [DW-1:0] v);
        int b0, w0, d0;
        b0 = busy_cnt; w0 = we_cnt; d0 = done_cnt;
        pulse_fill(v);
        wait_done("fill_done_seen");
        repeat (4) @(negedge clk);
        check_val("fill_busy_cycles", 32'(busy_cnt - b0), 32'(BUSY_EXP));
        check_val("fill_we_cycles", 32'(we_cnt - w0), 32'(DP));
        check_val("fill_done_pulses", 32'(done_cnt - d0), 32'd1);
        for (int i = 0; i < DP; i++) model[i] = v;
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < DP; i++) if (ram_mem[i] !== model[i]) bad++;
        check_val(tag, 32'(bad), 32'd0);
    endtask

    task automatic scan_run(input int ncyc, input bit with_writes, output int nchg, output bit wrapped);
        logic [AW-1:0] prev;
        int last_t, iv;
        bit prev_wr;
        prev = cur_addr; last_t = -1; nchg = 0; wrapped = 1'b0; prev_wr = 1'b0;
        scan_en = 1'b1;
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk); #1;
            wr_req = 1'b0;
            if (with_writes && !prev_wr && $urandom_range(0, 5) == 0) begin
                wr_addr = cur_addr + 5'd16;
                wr_data = DW'($urandom);
                wr_req  = 1'b1;
                model[wr_addr] = wr_data;
            end
            prev_wr = wr_req;
            @(negedge clk);
            if (cur_addr !== prev) begin
                check_val("scan_seq", 32'(cur_addr), 32'((prev + 1) % DP));
                check_val("scan_data", 32'(cur_data), 32'(model[cur_addr]));
                if (last_t >= 0) begin
                    iv = t - last_t;
                    if (with_writes) check_val("scan_interval_w", 32'(iv >= DIV - 1 && iv <= DIV + 1), 32'd1);
                    else             check_val("scan_interval", 32'(iv), 32'(DIV));
                end
                if (cur_addr == 5'd0 && prev == 5'd31) wrapped = 1'b1;
                last_t = t; nchg++; prev = cur_addr;
            end
        end
        @(posedge clk); #1;
        wr_req = 1'b0;
        scan_en = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int nchg, w0, d0;
        bit wrapped;
        logic [DW-1:0] v;
        logic [DW-1:0] old_model [DP];

        rst = 1'b1; wr_req = 1'b0; fill_start = 1'b0; scan_en = 1'b0;
        wr_addr = '0; wr_data = '0; fill_value = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_we", 32'(ram_we), 32'd0);
        check_val("rst_addr", 32'(ram_addr), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_cur_data", 32'(cur_data), 32'd0);
        check_val("rst_cur_addr", 32'(cur_addr), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        fill_and_check(4'hA);
        compare_mem("fill_a_contents");
        check_val("fill_a_err", 32'(err), 32'd0);

        w0 = we_cnt;
        @(posedge clk); #1;
        wr_addr = 5'd5; wr_data = 4'h3; wr_req = 1'b1;
        @(posedge clk); #1;
        wr_req = 1'b0;
        model[5] = 4'h3;
        repeat (4) @(negedge clk);
        check_val("wr_we_cycles", 32'(we_cnt - w0), 32'd1);
        check_val("wr_addr", 32'(we_addr_last), 32'd5);
        check_val("wr_data", 32'(we_din_last), 32'd3);
        compare_mem("wr_contents");

        scan_run(140, 1'b0, nchg, wrapped);
        check_val("scan_wrap", 32'(wrapped), 32'd1);
        check_val("scan_steps", 32'(nchg >= 32), 32'd1);

        v = DW'($urandom_range(0, 9));
        fill_and_check(v);
        compare_mem("fill_rand_contents");
        scan_run(260, 1'b1, nchg, wrapped);
        check_val("scan_w_steps", 32'(nchg >= 55), 32'd1);
        compare_mem("scan_w_contents");

`ifdef RAM_CTRL_VERIFY_EN
        flip_en = 1'b1;
        fill_and_check(4'hC);
        check_val("verify_err_set", 32'(err), 32'd1);
        flip_en = 1'b0;
        repeat (5) @(negedge clk);
        check_val("verify_err_sticky", 32'(err), 32'd1);
        pulse_fill(4'h6);
        @(negedge clk);
        check_val("verify_err_cleared", 32'(err), 32'd0);
        wait_done("verify_done_seen");
        @(negedge clk);
        check_val("verify_err_clean", 32'(err), 32'd0);
        for (int i = 0; i < DP; i++) model[i] = 4'h6;
`endif

        for (int i = 0; i < DP; i++) old_model[i] = model[i];
        v = (model[0] == 4'h5) ? 4'h9 : 4'h5;
        d0 = done_cnt;
        pulse_fill(v);
        repeat (8) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rstfill_we", 32'(ram_we), 32'd0);
        check_val("rstfill_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check_val("rstfill_no_done", 32'(done_cnt - d0), 32'd0);
        for (int i = 0; i < 9; i++) check_val("rstfill_written", 32'(ram_mem[i]), 32'(v));
        for (int i = 11; i < DP; i++) check_val("rstfill_kept", 32'(ram_mem[i]), 32'(old_model[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
